// File: rtl/uart_recv.sv
// 8N1 UART receiver: 3-flop input synchroniser, mid-bit sampling, one-cycle
// done/frame-error strobes and a busy flag.
module uart_recv #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BIT_W   = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         rxd_q;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;

  logic line_c, start_flag_c, at_mid_c, at_wrap_c;

  assign line_c       = rxd_q[1];
  assign start_flag_c = rxd_q[2] & ~rxd_q[1];
  assign at_mid_c     = (clk_cnt_q == CNT_MID);
  assign at_wrap_c    = (clk_cnt_q == CNT_MAX);

  // State and datapath registers; synchroniser resets to the idle (high) level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      rxd_q     <= 3'b111;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rxd_q     <= {rxd_q[1:0], uart_rxd};
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; STOP exits at its midpoint so a back-to-back start edge is caught.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_flag_c) state_d = START;
      START: begin
        if (at_mid_c && line_c) state_d = IDLE;
        else if (at_wrap_c)     state_d = DATA;
      end
      DATA:  if (at_wrap_c && (bit_cnt_q == BIT_W'(7))) state_d = STOP;
      STOP:  if (at_mid_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and output strobes.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = (state_d != IDLE);
    if (state_q == IDLE) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      clk_cnt_d = at_wrap_c ? '0 : CNT_W'(clk_cnt_q + CNT_W'(1));
    end
    if (state_q == DATA) begin
      if (at_mid_c)  shift_d[bit_cnt_q] = line_c;
      if (at_wrap_c) bit_cnt_d = BIT_W'(bit_cnt_q + BIT_W'(1));
    end
    if ((state_q == STOP) && at_mid_c) begin
      if (line_c) begin
        data_d = shift_q;
        done_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign uart_data = data_q;
  assign uart_done = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: directed frames push expected pulses into a
// queue, a negedge monitor pops and compares whenever a strobe appears.
module tb_uart_recv;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd1 = 1'b1;
  logic       rxd2 = 1'b1;
  logic [7:0] data1, data2;
  logic       done1, done2, ferr1, ferr2, busy1, busy2;

  uart_recv #(.CLK_FREQ(1000000), .UART_BPS(100000)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd1),
    .uart_data(data1), .uart_done(done1), .frame_err(ferr1), .rx_busy(busy1)
  );

  uart_recv dut2 (
    .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd2),
    .uart_data(data2), .uart_done(done2), .frame_err(ferr2), .rx_busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  model1 = 8'h00;
  logic [7:0]  model2 = 8'h00;
  int unsigned last_t0 = 0;
  int unsigned t = 0;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  logic        busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rxd2 = v;
    else       rxd1 = v;
  endtask

  // Call right after a posedge; the start bit is captured on the next edge (T0).
  task automatic send(input bit which, input logic [7:0] b, input bit stop,
                      input int unsigned bl, input bit expect_pulse);
    exp_t e;
    #1;
    last_t0 = cyc + 1;
    if (expect_pulse) begin
      e.err = !stop;
      e.cyc = last_t0 + 3 + 9 * bl + bl / 2;
      if (which == 1'b0) begin
        if (stop) model1 = b;
        e.data = model1;
        q1.push_back(e);
      end else begin
        if (stop) model2 = b;
        e.data = model2;
        q2.push_back(e);
      end
    end
    drive(which, 1'b0);
    repeat (bl) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 drive(which, b[i]);
      repeat (bl) @(posedge clk);
    end
    #1 drive(which, stop);
    repeat (bl) @(posedge clk);
  endtask

  // Monitor for the fast instance: exact pulse cycle is checked.
  always @(negedge clk) begin
    if (done1 || ferr1) begin
      exp_t e;
      check("dut1 done/ferr exclusive", {31'd0, done1 & ferr1}, 32'd0);
      check("dut1 pulse expected", {31'd0, q1.size() > 0}, 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1 pulse kind ferr", {31'd0, ferr1}, {31'd0, e.err});
        check("dut1 uart_data", {24'd0, data1}, {24'd0, e.data});
        check("dut1 pulse cycle", cyc, e.cyc);
      end
    end
    if (busy1 && !busy_prev) rise_cyc = cyc;
    if (!busy1 && busy_prev) fall_cyc = cyc;
    busy_prev = busy1;
  end

  // Monitor for the default-parameter instance (drifted bit period).
  always @(negedge clk) begin
    if (done2 || ferr2) begin
      exp_t e;
      check("dut2 done/ferr exclusive", {31'd0, done2 & ferr2}, 32'd0);
      check("dut2 pulse expected", {31'd0, q2.size() > 0}, 32'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("dut2 pulse kind ferr", {31'd0, ferr2}, {31'd0, e.err});
        check("dut2 uart_data", {24'd0, data2}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset uart_data", {24'd0, data1}, 32'h00);
    check("reset uart_done", {31'd0, done1}, 32'd0);
    check("reset frame_err", {31'd0, ferr1}, 32'd0);
    check("reset rx_busy", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single ideal frame and busy window.
    send(1'b0, 8'h55, 1'b1, 10, 1'b1);
    t = last_t0;
    repeat (5) @(posedge clk);
    check("t1 busy rise", rise_cyc, t + 2);
    check("t1 busy fall", fall_cyc, t + 98);

    // Back-to-back frames, no idle gap.
    repeat (4) @(posedge clk);
    send(1'b0, 8'hA3, 1'b1, 10, 1'b1);
    send(1'b0, 8'h0F, 1'b1, 10, 1'b1);

    // Three-cycle glitch is a false start, then a good frame.
    repeat (4) @(posedge clk);
    #1 rxd1 = 1'b0;
    t = cyc + 1;
    repeat (3) @(posedge clk);
    #1 rxd1 = 1'b1;
    repeat (20) @(posedge clk);
    check("t3 glitch busy rise", rise_cyc, t + 2);
    check("t3 glitch busy fall", fall_cyc, t + 8);
    send(1'b0, 8'h5A, 1'b1, 10, 1'b1);

    // Stop bit low: frame error, data held.
    repeat (4) @(posedge clk);
    send(1'b0, 8'h3C, 1'b0, 10, 1'b1);
    #1 rxd1 = 1'b1;
    repeat (10) @(posedge clk);
    check("t4 data held after ferr", {24'd0, data1}, 32'h5A);

    // Reset in the middle of a 0xFF frame.
    #1 rxd1 = 1'b0;
    t = cyc + 1;
    repeat (10) @(posedge clk);
    #1 rxd1 = 1'b1;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5 reset uart_data", {24'd0, data1}, 32'h00);
    check("t5 reset uart_done", {31'd0, done1}, 32'd0);
    check("t5 reset frame_err", {31'd0, ferr1}, 32'd0);
    check("t5 reset rx_busy", {31'd0, busy1}, 32'd0);
    model1 = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    check("t5 data after release", {24'd0, data1}, 32'h00);
    send(1'b0, 8'h81, 1'b1, 10, 1'b1);

    // Default parameters, bit period stretched by 2%.
    repeat (5) @(posedge clk);
    send(1'b1, 8'h00, 1'b1, 5312, 1'b1);
    repeat (20) @(posedge clk);

    check("dut1 expected pulses all seen", q1.size(), 32'd0);
    check("dut2 expected pulses all seen", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
# uart_recv

UART receiver for 8N1 frames: no parity, LSB first, one stop bit, line idle high. It is the receive-side counterpart of the team's `uart_send` transmitter and uses the same `CLK_FREQ`/`UART_BPS` parameterisation. It sits between the board RX pin and user logic such as the flash-ID debug path and loopback tests. Per frame it outputs one data byte with a single-cycle strobe, and it reports false starts and framing errors.

## Interface
Parameters
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 9600: baud rate.
- `BPS_CNT` (localparam) = `CLK_FREQ/UART_BPS`: clocks per bit. Legal range is 4..65535; `clk_cnt` is 16 bits wide.

Ports
- `sys_clk`  in  1  system clock. This is the block's only clock; all logic is on the rising edge.
- `sys_rst`  in  1  asynchronous reset, active-high.
- `uart_rxd`  in  1  serial input, asynchronous to `sys_clk`.
- `uart_data`  out  8  last correctly received byte. Holds its value until the next good frame.
- `uart_done`  out  1  one-cycle pulse; `uart_data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_busy`  out  1  high while state ≠ IDLE.

## Operation
Input synchronisation
- `uart_rxd` passes through three flops: d0 → d1 → d2.
- All three flops reset to 1.
- `start_flag` = d2 & ~d1 (falling edge on the synchronised line).
- The line is sampled from d1.

State machine: IDLE, START, DATA, STOP.
- IDLE: when `start_flag` = 1, go to START, `clk_cnt` ← 0, `bit_cnt` ← 0.
- In every state other than IDLE, `clk_cnt` counts 0..`BPS_CNT`-1 and then wraps to 0.
- Mid-bit sample point: the cycle where `clk_cnt` == `BPS_CNT/2` (integer division).
- START, at the sample point:
  - d1 = 1: false start. Go to IDLE with no output pulses.
  - d1 = 0: continue. On the `clk_cnt` wrap, go to DATA.
- DATA, at each sample point: shift_reg[`bit_cnt`] ← d1. On each wrap, `bit_cnt` increments. After the wrap at `bit_cnt` = 7, go to STOP.
- STOP, at the sample point:
  - d1 = 1: `uart_data` ← shift_reg, pulse `uart_done`.
  - d1 = 0: pulse `frame_err`; `uart_data` is unchanged.
  - Either way, go to IDLE at this same point (half-bit early), so a back-to-back start edge is caught.
- Falling edges while not in IDLE are ignored.
- `uart_done` and `frame_err` are never high in the same cycle.

## Timing
Reset values
- `uart_data` = 0x00, `uart_done` = 0, `frame_err` = 0, `rx_busy` = 0.
- State = IDLE, counters = 0, shift_reg = 0.

Latency
- Let T0 be the first `sys_clk` edge at which d0 captures 0.
- START is entered at T0+2; `rx_busy` rises at T0+2.
- `uart_done`/`frame_err` are high for exactly the cycle starting at T0 + 3 + 9·`BPS_CNT` + `BPS_CNT/2`.
- `rx_busy` falls in that same cycle.

Boundary conditions
- Back-to-back frames with no idle gap are received without loss. Stop-bit width is only checked at its midpoint.
- Glitch: a low pulse shorter than `BPS_CNT/2` that starts in IDLE is a false start. `rx_busy` is high from T0+2 through T0+2+`BPS_CNT/2`, then drops.
- Reset asserted mid-frame: immediately (asynchronously) return to reset values. The partial byte is discarded.
- Reset released while `uart_rxd` is low: a start edge is detected 2 cycles after release. If the line stays low for the whole frame, the result is `frame_err`.
- Sampling tolerance: ±`BPS_CNT/2` clocks of cumulative drift over 10 bits.

## Test plan
Use `CLK_FREQ`=1000000 and `UART_BPS`=100000, so `BPS_CNT`=10, unless noted.
1. Send 0x55 with an ideal 10-clock bit period → `uart_done` high for 1 cycle at T0+98, `uart_data`=0x55, `frame_err` never high, `rx_busy` high T0+2..T0+97.
2. Send 0xA3 then 0x0F back-to-back with no idle gap → two `uart_done` pulses 100 cycles apart, carrying 0xA3 then 0x0F.
3. Drive `uart_rxd` low for 3 cycles in idle → no `uart_done`/`frame_err`, `rx_busy` high for 6 cycles, then 0x5A is received correctly immediately afterwards.
4. Send 0x3C with the stop bit forced low → `frame_err` pulses at T0+98, `uart_done` stays 0, `uart_data` keeps its previous value.
5. Assert `sys_rst` at T0+50 of a 0xFF frame, release 5 cycles later with the line high → all outputs at reset values, no pulses; the next 0x81 frame is received correctly.
6. Default parameters (`BPS_CNT`=5208), send 0x00, bit period stretched by 2% → `uart_data`=0x00, `uart_done` pulses once, no `frame_err`.
